// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory-stage data access unit:
// access-type codes, FSM states, byte-enable patterns and store/alignment helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    DT_WORD  = 2'b00,
    DT_HALF  = 2'b01,
    DT_BYTE  = 2'b10,
    DT_UBYTE = 2'b11
  } dmem_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Words must sit on a 4-byte boundary, halves on a 2-byte boundary.
  function automatic logic is_misaligned(dmem_type_e t, logic [1:0] a);
    case (t)
      DT_WORD: return a != 2'b00;
      DT_HALF: return a[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(dmem_type_e t, logic [1:0] a);
    case (t)
      DT_WORD: return BE_WORD;
      DT_HALF: return a[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_BYTE0 << a;
    endcase
  endfunction

  // Replicate the right-aligned store data into every lane; byte enables pick the lane.
  function automatic logic [31:0] store_lanes(dmem_type_e t, logic [31:0] d);
    case (t)
      DT_WORD: return d;
      DT_HALF: return {2{d[15:0]}};
      default: return {4{d[7:0]}};
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: picks the addressed lane out of the bus word and
// sign- or zero-extends it according to the access type.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  dmem_type,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  // Lane select and extension, purely combinational.
  always_comb begin
    // NOTE: every output of an always_comb gets a value on every path, or a latch is inferred.
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    byte_lane = 8'(rdata >> {addr, 3'b000});
    case (dmem_type_e'(dmem_type))
      DT_WORD: data = rdata;
      DT_HALF: data = {{16{half_lane[15]}}, half_lane};
      DT_BYTE: data = {{24{byte_lane[7]}}, byte_lane};
      default: data = {24'b0, byte_lane};
    endcase
  end

endmodule

// File: rtl/stage_mem_access.sv
// Memory-stage data access unit. Accepts the EX request, runs one
// request/grant/response bus transaction, formats load data and emits the
// write-back record; stalls the pipeline while an access is in flight.
// Optional build macro MEM_TIMEOUT_EN adds a REQ+WAIT watchdog of
// TIMEOUT_CYCLES bus cycles that aborts the access with a timeout_o pulse.
module stage_mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ex_valid_i,
  input  logic        dmem_ena_i,
  input  logic        dmem_wena_i,
  input  logic [1:0]  dmem_type_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  rd_waddr_i,
  input  logic        rd_sel_i,
  input  logic        rd_wena_i,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_waddr_o,
  output logic        rd_wena_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  state_e      state;
  dmem_type_e  req_type;
  dmem_type_e  type_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_waddr_q;
  logic        rd_sel_q;
  logic        rd_wena_q;
  logic        misaligned;
  logic        mem_accept;
  logic [31:0] load_data;

  assign req_type   = dmem_type_e'(dmem_type_i);
  assign misaligned = is_misaligned(req_type, alu_result_i[1:0]);
  assign mem_accept = (state == S_IDLE) && ex_valid_i && dmem_ena_i && !misaligned;

  // Freeze IF/ID/EX from the accepting cycle until the response lands; DONE lets EX advance.
  assign stall_o = (state == S_REQ) || (state == S_WAIT) || mem_accept;

  mem_load_align u_load_align (
    .addr      (addr_q[1:0]),
    .dmem_type (type_q),
    .rdata     (bus_rdata_i),
    .data      (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_expired;
  // The access gives up on the cycle that completes the TIMEOUT_CYCLES-th REQ/WAIT cycle.
  assign tmo_expired = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Access FSM with registered bus and write-back outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      state       <= S_IDLE;
      type_q      <= DT_WORD;
      addr_q      <= '0;
      rd_waddr_q  <= '0;
      rd_sel_q    <= 1'b0;
      rd_wena_q   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      wb_valid_o  <= 1'b0;
      wb_data_o   <= '0;
      rd_waddr_o  <= '0;
      rd_wena_o   <= 1'b0;
      misalign_o  <= 1'b0;
      timeout_o   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid_i && !dmem_ena_i) begin
            wb_valid_o <= 1'b1;
            wb_data_o  <= alu_result_i;
            rd_waddr_o <= rd_waddr_i;
            rd_wena_o  <= rd_wena_i;
          end else if (ex_valid_i && misaligned) begin
            wb_valid_o <= 1'b1;
            misalign_o <= 1'b1;
            wb_data_o  <= alu_result_i;
            rd_waddr_o <= rd_waddr_i;
            rd_wena_o  <= 1'b0;
          end else if (mem_accept) begin
            state       <= S_REQ;
            type_q      <= req_type;
            addr_q      <= alu_result_i;
            rd_waddr_q  <= rd_waddr_i;
            rd_sel_q    <= rd_sel_i;
            rd_wena_q   <= rd_wena_i;
            bus_req_o   <= 1'b1;
            bus_we_o    <= dmem_wena_i;
            bus_addr_o  <= {alu_result_i[31:2], 2'b00};
            bus_be_o    <= byte_enables(req_type, alu_result_i[1:0]);
            bus_wdata_o <= store_lanes(req_type, rt_data_i);
`ifdef MEM_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        S_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= S_WAIT;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_expired) begin
            bus_req_o  <= 1'b0;
            state      <= S_DONE;
            wb_valid_o <= 1'b1;
            timeout_o  <= 1'b1;
            wb_data_o  <= addr_q;
            rd_waddr_o <= rd_waddr_q;
            rd_wena_o  <= 1'b0;
          end
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            state      <= S_DONE;
            wb_valid_o <= 1'b1;
            wb_data_o  <= rd_sel_q ? load_data : addr_q;
            rd_waddr_o <= rd_waddr_q;
            rd_wena_o  <= rd_wena_q;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_expired) begin
            state      <= S_DONE;
            wb_valid_o <= 1'b1;
            timeout_o  <= 1'b1;
            wb_data_o  <= addr_q;
            rd_waddr_o <= rd_waddr_q;
            rd_wena_o  <= 1'b0;
          end
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem_access.sv
// Directed bench for stage_mem_access: ALU pass-through, aligned loads and
// stores on zero-wait and slow buses, misaligned rejection, reset mid-access
// and (with MEM_TIMEOUT_EN) the watchdog abort.
module tb_stage_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ex_valid_i, dmem_ena_i, dmem_wena_i;
  logic [1:0]  dmem_type_i;
  logic [31:0] alu_result_i, rt_data_i;
  logic [4:0]  rd_waddr_i;
  logic        rd_sel_i, rd_wena_i;
  logic        stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_waddr_o;
  logic        rd_wena_o, misalign_o, timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations collected by run_access for the scenario tasks to judge.
  logic [31:0] obs_addr, obs_wdata, obs_wb_data;
  logic [3:0]  obs_be;
  logic        obs_we, obs_rd_wena;
  logic [4:0]  obs_rd_waddr;
  int          obs_wb_cycle, obs_pulses;
  bit          obs_stall_ok, obs_req_ok;

  always #5 clk_i = ~clk_i;

  stage_mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .ex_valid_i   (ex_valid_i),
    .dmem_ena_i   (dmem_ena_i),
    .dmem_wena_i  (dmem_wena_i),
    .dmem_type_i  (dmem_type_i),
    .alu_result_i (alu_result_i),
    .rt_data_i    (rt_data_i),
    .rd_waddr_i   (rd_waddr_i),
    .rd_sel_i     (rd_sel_i),
    .rd_wena_i    (rd_wena_i),
    .stall_o      (stall_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_data_o    (wb_data_o),
    .rd_waddr_o   (rd_waddr_o),
    .rd_wena_o    (rd_wena_o),
    .misalign_o   (misalign_o),
    .timeout_o    (timeout_o)
  );

  task automatic idle_inputs();
    ex_valid_i = 0; dmem_ena_i = 0; dmem_wena_i = 0; dmem_type_i = 2'b00;
    alu_result_i = '0; rt_data_i = '0; rd_waddr_i = '0; rd_sel_i = 0; rd_wena_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
  endtask

  task automatic drive_ex(input logic mem, input logic we, input logic [1:0] t, input logic [31:0] addr,
                          input logic [31:0] rt, input logic sel, input logic [4:0] rd, input logic rd_we);
    ex_valid_i = 1; dmem_ena_i = mem; dmem_wena_i = we; dmem_type_i = t; alu_result_i = addr;
    rt_data_i = rt; rd_sel_i = sel; rd_waddr_i = rd; rd_wena_i = rd_we;
  endtask

  // One memory instruction held in EX while stalled. Grant comes in cycle 1+gw,
  // the response in cycle 2+gw+rw, so the record is expected in cycle 3+gw+rw.
  // With early_rv a bogus response is also offered alongside the grant.
  task automatic run_access(input logic [1:0] t, input logic we, input logic [31:0] addr, input logic [31:0] rt,
                            input logic [31:0] rdata, input logic sel, input logic [4:0] rd,
                            input int gw, input int rw, input bit early_rv);
    int exp_wb;
    exp_wb = 3 + gw + rw;
    @(posedge clk_i); #1;
    drive_ex(1'b1, we, t, addr, rt, sel, rd, ~we);
    @(negedge clk_i);
    obs_stall_ok = (stall_o === 1'b1);
    obs_req_ok   = (bus_req_o === 1'b0);
    obs_pulses = 0; obs_wb_cycle = 0; obs_wb_data = 'x; obs_rd_waddr = 'x; obs_rd_wena = 'x;
    for (int c = 1; c <= exp_wb + 2; c++) begin
      @(posedge clk_i); #1;
      bus_gnt_i    = (c == 1 + gw);
      bus_rvalid_i = (c == 2 + gw + rw) || (early_rv && c == 1 + gw);
      bus_rdata_i  = (c == 2 + gw + rw) ? rdata : ~rdata;
      if (c == exp_wb + 1) idle_inputs();
      @(negedge clk_i);
      if (c == 1) begin
        obs_addr = bus_addr_o; obs_be = bus_be_o; obs_wdata = bus_wdata_o; obs_we = bus_we_o;
      end
      if (bus_req_o !== (c <= 1 + gw)) obs_req_ok = 0;
      if (c <= 1 + gw && bus_addr_o !== obs_addr) obs_req_ok = 0;
      if (stall_o !== (c < exp_wb)) obs_stall_ok = 0;
      if (wb_valid_o === 1'b1) begin
        obs_pulses++; obs_wb_cycle = c; obs_wb_data = wb_data_o;
        obs_rd_waddr = rd_waddr_o; obs_rd_wena = rd_wena_o;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_i = 0;
    repeat (2) @(negedge clk_i);
    n_cmp++; if ({stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, wb_valid_o, wb_data_o,
                  rd_waddr_o, rd_wena_o, misalign_o, timeout_o} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got req=%b wb=%b addr=%h data=%h want all zero", bus_req_o, wb_valid_o, bus_addr_o, wb_data_o);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1;
  endtask

  task automatic test_alu_op();
    bit stall_seen;
    @(posedge clk_i); #1;
    drive_ex(1'b0, 1'b0, 2'b00, 32'h0000_1234, 32'h0, 1'b0, 5'd5, 1'b1);
    @(negedge clk_i); stall_seen = stall_o;
    @(posedge clk_i); #1; idle_inputs();
    @(negedge clk_i); stall_seen |= stall_o;
    n_cmp++; if (wb_valid_o !== 1'b1) begin n_bad++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid_o); end
    n_cmp++; if (wb_data_o !== 32'h0000_1234) begin n_bad++; $display("FAIL alu_wb_data: got %h want 00001234", wb_data_o); end
    n_cmp++; if (rd_waddr_o !== 5'd5 || rd_wena_o !== 1'b1) begin n_bad++; $display("FAIL alu_rd: got %0d/%b want 5/1", rd_waddr_o, rd_wena_o); end
    @(negedge clk_i); stall_seen |= stall_o;
    n_cmp++; if (wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL alu_pulse_len: got %b want 0", wb_valid_o); end
    n_cmp++; if (stall_seen !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", stall_seen); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk_i); #1; drive_ex(1'b0, 1'b0, 2'b00, 32'h0000_0011, 32'h0, 1'b0, 5'd1, 1'b1);
    @(posedge clk_i); #1; drive_ex(1'b0, 1'b0, 2'b00, 32'h0000_0022, 32'h0, 1'b0, 5'd2, 1'b1);
    @(negedge clk_i);
    n_cmp++; if ({wb_valid_o, wb_data_o, rd_waddr_o} !== {1'b1, 32'h11, 5'd1}) begin n_bad++; $display("FAIL b2b_first: got %b %h %0d want 1 00000011 1", wb_valid_o, wb_data_o, rd_waddr_o); end
    @(posedge clk_i); #1; idle_inputs();
    @(negedge clk_i);
    n_cmp++; if ({wb_valid_o, wb_data_o, rd_waddr_o} !== {1'b1, 32'h22, 5'd2}) begin n_bad++; $display("FAIL b2b_second: got %b %h %0d want 1 00000022 2", wb_valid_o, wb_data_o, rd_waddr_o); end
  endtask

  task automatic test_load_byte();
    run_access(2'b10, 1'b0, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1'b1, 5'd7, 0, 0, 0);
    n_cmp++; if (obs_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be: got %b want 1000", obs_be); end
    n_cmp++; if (obs_addr !== 32'h100 || obs_we !== 1'b0) begin n_bad++; $display("FAIL lb_addr_we: got %h/%b want 00000100/0", obs_addr, obs_we); end
    n_cmp++; if (obs_wb_cycle !== 3 || obs_pulses !== 1) begin n_bad++; $display("FAIL lb_timing: got cycle %0d pulses %0d want 3/1", obs_wb_cycle, obs_pulses); end
    n_cmp++; if (obs_wb_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h want ffffff80", obs_wb_data); end
    n_cmp++; if (obs_rd_waddr !== 5'd7 || obs_rd_wena !== 1'b1) begin n_bad++; $display("FAIL lb_rd: got %0d/%b want 7/1", obs_rd_waddr, obs_rd_wena); end
    n_cmp++; if (!obs_stall_ok || !obs_req_ok) begin n_bad++; $display("FAIL lb_handshake: got stall_ok=%b req_ok=%b want 1/1", obs_stall_ok, obs_req_ok); end
    run_access(2'b11, 1'b0, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1'b1, 5'd7, 0, 0, 0);
    n_cmp++; if (obs_wb_data !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_data: got %h want 00000080", obs_wb_data); end
    run_access(2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h80AA_BBCC, 1'b1, 5'd8, 0, 0, 0);
    n_cmp++; if (obs_wb_data !== 32'hFFFF_FFBB || obs_be !== 4'b0010) begin n_bad++; $display("FAIL lb_lane1: got %h/%b want ffffffbb/0010", obs_wb_data, obs_be); end
    run_access(2'b11, 1'b0, 32'h0000_0108, 32'h0, 32'h1122_3344, 1'b0, 5'd8, 0, 0, 0);
    n_cmp++; if (obs_wb_data !== 32'h0000_0108) begin n_bad++; $display("FAIL lbu_nosel: got %h want 00000108", obs_wb_data); end
  endtask

  task automatic test_load_half_word();
    run_access(2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 1'b1, 5'd4, 0, 0, 0);
    n_cmp++; if (obs_wb_data !== 32'hFFFF_80AA || obs_be !== 4'b1100) begin n_bad++; $display("FAIL lh_data: got %h/%b want ffff80aa/1100", obs_wb_data, obs_be); end
    run_access(2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b1, 5'd9, 3, 2, 0);
    n_cmp++; if (obs_wb_cycle !== 8 || obs_pulses !== 1) begin n_bad++; $display("FAIL lw_slow_timing: got cycle %0d pulses %0d want 8/1", obs_wb_cycle, obs_pulses); end
    n_cmp++; if (obs_wb_data !== 32'h1234_5678 || obs_be !== 4'b1111) begin n_bad++; $display("FAIL lw_slow_data: got %h/%b want 12345678/1111", obs_wb_data, obs_be); end
    n_cmp++; if (!obs_stall_ok || !obs_req_ok) begin n_bad++; $display("FAIL lw_slow_handshake: got stall_ok=%b req_ok=%b want 1/1", obs_stall_ok, obs_req_ok); end
  endtask

  task automatic test_gnt_rvalid_same();
    run_access(2'b00, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_0001, 1'b1, 5'd3, 0, 0, 1);
    n_cmp++; if (obs_wb_cycle !== 3 || obs_wb_data !== 32'hCAFE_0001) begin n_bad++; $display("FAIL gnt_rvalid_same: got cycle %0d data %h want 3 cafe0001", obs_wb_cycle, obs_wb_data); end
  endtask

  task automatic test_store();
    run_access(2'b01, 1'b1, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 1'b0, 5'd0, 0, 0, 0);
    n_cmp++; if (obs_addr !== 32'h100 || obs_be !== 4'b1100) begin n_bad++; $display("FAIL sh_addr_be: got %h/%b want 00000100/1100", obs_addr, obs_be); end
    n_cmp++; if (obs_wdata !== 32'hBEEF_BEEF || obs_we !== 1'b1) begin n_bad++; $display("FAIL sh_wdata_we: got %h/%b want beefbeef/1", obs_wdata, obs_we); end
    n_cmp++; if (obs_wb_cycle !== 3 || obs_rd_wena !== 1'b0) begin n_bad++; $display("FAIL sh_record: got cycle %0d rd_wena %b want 3/0", obs_wb_cycle, obs_rd_wena); end
    run_access(2'b10, 1'b1, 32'h0000_0101, 32'h1234_56A5, 32'h0, 1'b0, 5'd0, 1, 0, 0);
    n_cmp++; if (obs_wdata !== 32'hA5A5_A5A5 || obs_be !== 4'b0010) begin n_bad++; $display("FAIL sb_lanes: got %h/%b want a5a5a5a5/0010", obs_wdata, obs_be); end
    run_access(2'b00, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0, 0, 1, 0);
    n_cmp++; if (obs_wdata !== 32'hDEAD_BEEF || obs_be !== 4'b1111 || obs_addr !== 32'h200) begin n_bad++; $display("FAIL sw_fields: got %h/%b/%h want deadbeef/1111/00000200", obs_wdata, obs_be, obs_addr); end
  endtask

  task automatic test_misaligned();
    logic [1:0]  types [2] = '{2'b00, 2'b01};
    logic [31:0] addrs [2] = '{32'h0000_0101, 32'h0000_0103};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      drive_ex(1'b1, 1'b0, types[i], addrs[i], 32'h0, 1'b1, 5'd9, 1'b1);
      @(negedge clk_i);
      n_cmp++; if (stall_o !== 1'b0 || bus_req_o !== 1'b0) begin n_bad++; $display("FAIL misalign_accept_%0d: got stall=%b req=%b want 0/0", i, stall_o, bus_req_o); end
      @(posedge clk_i); #1; idle_inputs();
      @(negedge clk_i);
      n_cmp++; if ({wb_valid_o, misalign_o, rd_wena_o, bus_req_o} !== 4'b1100) begin n_bad++; $display("FAIL misalign_record_%0d: got valid/mis/wena/req=%b%b%b%b want 1100", i, wb_valid_o, misalign_o, rd_wena_o, bus_req_o); end
      @(negedge clk_i);
      n_cmp++; if (wb_valid_o !== 1'b0 || misalign_o !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse_%0d: got %b/%b want 0/0", i, wb_valid_o, misalign_o); end
    end
  endtask

  task automatic test_reset_mid_access();
    bit quiet;
    @(posedge clk_i); #1; drive_ex(1'b1, 1'b0, 2'b00, 32'h0000_0300, 32'h0, 1'b1, 5'd6, 1'b1);
    @(posedge clk_i); #1; bus_gnt_i = 1;
    @(posedge clk_i); #1; bus_gnt_i = 0; idle_inputs(); rst_n_i = 0;
    @(negedge clk_i);
    n_cmp++; if ({stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, wb_valid_o, wb_data_o,
                  rd_waddr_o, rd_wena_o, misalign_o, timeout_o} !== '0) begin
      n_bad++; $display("FAIL reset_wait_outputs: got req=%b addr=%h be=%b want all zero", bus_req_o, bus_addr_o, bus_be_o);
    end
    @(posedge clk_i); #1; rst_n_i = 1;
    @(posedge clk_i); #1; bus_rvalid_i = 1; bus_rdata_i = 32'h5555_AAAA;
    quiet = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (wb_valid_o !== 1'b0 || bus_req_o !== 1'b0 || stall_o !== 1'b0) quiet = 0;
      @(posedge clk_i); #1; bus_rvalid_i = 0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL reset_late_rvalid: got quiet=%b want 1", quiet); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int first;
    logic wena_at, req_at, valid_at;
    bit req_ok;
    first = 0; req_ok = 1; wena_at = 'x; req_at = 'x; valid_at = 'x;
    @(posedge clk_i); #1; drive_ex(1'b1, 1'b0, 2'b00, 32'h0000_0400, 32'h0, 1'b1, 5'd3, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk_i); #1;
      if (c == 6) idle_inputs();
      @(negedge clk_i);
      if (c <= 4 && bus_req_o !== 1'b1) req_ok = 0;
      if (timeout_o === 1'b1 && first == 0) begin
        first = c; wena_at = rd_wena_o; req_at = bus_req_o; valid_at = wb_valid_o;
      end
    end
    n_cmp++; if (first !== 5 || !req_ok) begin n_bad++; $display("FAIL timeout_cycle: got cycle %0d req_ok %b want 5/1", first, req_ok); end
    n_cmp++; if ({valid_at, wena_at, req_at} !== 3'b100) begin n_bad++; $display("FAIL timeout_record: got valid/wena/req=%b%b%b want 100", valid_at, wena_at, req_at); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_load_byte();
    test_load_half_word();
    test_gnt_rvalid_same();
    test_store();
    test_misaligned();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
